// File: rtl/aoi_pkg.sv
// ============================================================================
// Module : aoi_pkg
// Brief  : Shared types, constants and the AOI reference function for aoi_pipe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aoi_pkg;

    localparam int BIST_ERR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    // Behavioural AOI over the low terms*term_w bits of vec.
    function automatic logic aoi_ref(input logic [31:0] vec, input int terms, input int term_w);
        logic        w_any;
        logic        w_all;
        logic [31:0] w_sh;
        w_any = 1'b0;
        for (int t = 0; t < terms; t++) begin
            w_all = 1'b1;
            for (int b = 0; b < term_w; b++) begin
                w_sh  = vec >> (t * term_w + b);
                w_all = w_all & w_sh[0];
            end
            w_any = w_any | w_all;
        end
        return ~w_any;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aoi_bist_ctrl.sv
// ============================================================================
// Module : aoi_bist_ctrl
// Brief  : Exhaustive self-test sequencer/checker for aoi_pipe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_bist_ctrl
    import aoi_pkg::*;
#(
    parameter int  TERMS  = 2,
    parameter int  TERM_W = 2,
    localparam int N      = TERMS * TERM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bist_start,
    input  logic                  s2_v,
    input  logic                  s2_y,
    output logic                  inj_v,
    output logic [N-1:0]          inj_data,
    output logic                  flush,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic [BIST_ERR_W-1:0] bist_err_cnt
);

    localparam logic [N-1:0] c_sc_last = {N{1'b1}};
    localparam logic [N:0]   c_cc_last = {1'b0, {N{1'b1}}};

    bist_state_t           r_state;
    logic [N-1:0]          r_sc;
    logic [N:0]            r_cc;
    logic [BIST_ERR_W-1:0] r_err;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;

    logic                  w_start_ok;
    logic                  w_mismatch;
    logic [BIST_ERR_W-1:0] w_err_nxt;

    assign w_start_ok = bist_start && (r_state == IDLE || r_state == DONE);
    assign w_mismatch = s2_v && (s2_y != aoi_ref(32'(r_cc[N-1:0]), TERMS, TERM_W));
    assign w_err_nxt  = (w_mismatch && r_err != {BIST_ERR_W{1'b1}}) ? r_err + 1'b1 : r_err;

    assign inj_v        = (r_state == RUN);
    assign inj_data     = r_sc;
    assign flush        = w_start_ok;
    assign bist_busy    = r_busy;
    assign bist_done    = r_done;
    assign bist_pass    = r_pass;
    assign bist_err_cnt = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sc    <= '0;
            r_cc    <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state <= RUN;
                        r_sc    <= '0;
                        r_cc    <= '0;
                        r_err   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (s2_v) begin
                        r_cc  <= r_cc + 1'b1;
                        r_err <= w_err_nxt;
                    end
                    if (r_state == RUN) begin
                        r_sc <= r_sc + 1'b1;
                        if (r_sc == c_sc_last) begin
                            r_state <= DRAIN;
                        end
                    end else if (s2_v && r_cc == c_cc_last) begin
                        // Last result checked: the pipeline is empty from here on.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/aoi_pipe.sv
// ============================================================================
// Module : aoi_pipe
// Brief  : Two-stage valid/ready AND-OR-INVERT evaluator; optional exhaustive
//          self-test when AOI_PIPE_BIST_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_pipe
    import aoi_pkg::*;
#(
    parameter int  TERMS  = 2,
    parameter int  TERM_W = 2,
    localparam int N      = TERMS * TERM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_y,
    output logic [TERMS-1:0]      out_and
`ifdef AOI_PIPE_BIST_EN
    ,
    input  logic                  bist_start,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic [BIST_ERR_W-1:0] bist_err_cnt
`endif
);

    logic             r_s1_v;
    logic [TERMS-1:0] r_s1_and;
    logic             r_s2_v;
    logic [TERMS-1:0] r_s2_and;
    logic             r_s2_y;

    logic             w_s1_in_v;
    logic [N-1:0]     w_s1_in_data;
    logic [TERMS-1:0] w_in_and;
    logic             w_out_rdy;
    logic             w_adv1;
    logic             w_adv2;
    logic             w_flush;

    assign w_adv2 = ~r_s2_v | w_out_rdy;
    assign w_adv1 = ~r_s1_v | w_adv2;

    for (genvar t = 0; t < TERMS; t++) begin : g_term_and
        assign w_in_and[t] = &w_s1_in_data[t*TERM_W +: TERM_W];
    end

`ifdef AOI_PIPE_BIST_EN
    logic         w_inj_v;
    logic [N-1:0] w_inj_data;
    logic         w_chk_y;

    assign w_chk_y = r_s2_y;

    aoi_bist_ctrl #(
        .TERMS  (TERMS),
        .TERM_W (TERM_W)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .bist_start   (bist_start),
        .s2_v         (r_s2_v),
        .s2_y         (w_chk_y),
        .inj_v        (w_inj_v),
        .inj_data     (w_inj_data),
        .flush        (w_flush),
        .bist_busy    (bist_busy),
        .bist_done    (bist_done),
        .bist_pass    (bist_pass),
        .bist_err_cnt (bist_err_cnt)
    );

    // While the self-test owns the pipeline the external port is fenced off.
    assign w_out_rdy    = bist_busy ? 1'b1 : out_ready;
    assign w_s1_in_v    = bist_busy ? w_inj_v : in_valid;
    assign w_s1_in_data = bist_busy ? w_inj_data : in_data;
    assign in_ready     = w_adv1 & ~bist_busy;
    assign out_valid    = r_s2_v & ~bist_busy;
`else
    assign w_out_rdy    = out_ready;
    assign w_s1_in_v    = in_valid;
    assign w_s1_in_data = in_data;
    assign w_flush      = 1'b0;
    assign in_ready     = w_adv1;
    assign out_valid    = r_s2_v;
`endif

    assign out_y   = r_s2_y;
    assign out_and = r_s2_and;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_and <= '0;
        end else if (w_flush) begin
            r_s1_v <= 1'b0;
        end else if (w_adv1) begin
            r_s1_v <= w_s1_in_v;
            if (w_s1_in_v) begin
                r_s1_and <= w_in_and;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_s2_and <= '0;
            r_s2_y   <= 1'b0;
        end else if (w_flush) begin
            r_s2_v <= 1'b0;
        end else if (w_adv2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_and <= r_s1_and;
                r_s2_y   <= ~|r_s1_and;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aoi_pipe.sv
// ============================================================================
// Module : tb_aoi_pipe
// Brief  : Scoreboard bench for aoi_pipe (TERMS=2, TERM_W=2); BIST scenarios
//          on a TERMS=3 instance when AOI_PIPE_BIST_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aoi_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_y;
    logic [1:0] out_and;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       y;
        logic [1:0] a;
    } exp_t;

    exp_t sb[$];

    // Hand-derived y for v = 0..15: zero only for 3, 7, 11, 12..15.
    logic [15:0] c_y_tbl = 16'h0777;

`ifdef AOI_PIPE_BIST_EN
    logic       d_bist_start = 1'b0;
    logic       d_busy, d_done, d_pass;
    logic [7:0] d_err;

    logic       b_start = 1'b0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [5:0] b_in_data = 6'd0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b1;
    logic       b_out_y;
    logic [2:0] b_out_and;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_err;
    logic       flip_v;
`endif

    aoi_pipe #(.TERMS(2), .TERM_W(2)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_and      (out_and)
`ifdef AOI_PIPE_BIST_EN
        ,
        .bist_start   (d_bist_start),
        .bist_busy    (d_busy),
        .bist_done    (d_done),
        .bist_pass    (d_pass),
        .bist_err_cnt (d_err)
`endif
    );

`ifdef AOI_PIPE_BIST_EN
    aoi_pipe #(.TERMS(3), .TERM_W(2)) u_bist (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_data      (b_in_data),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_y        (b_out_y),
        .out_and      (b_out_and),
        .bist_start   (b_start),
        .bist_busy    (b_busy),
        .bist_done    (b_done),
        .bist_pass    (b_pass),
        .bist_err_cnt (b_err)
    );
`endif

    function automatic exp_t model(input logic [3:0] v);
        exp_t e;
        e.a = {&v[3:2], &v[1:0]};
        e.y = c_y_tbl[v];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        #3;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready stayed 0 for vector 0x%0h", v);
        end else begin
            sb.push_back(model(v));
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #5;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: pops on handshake, and holds stalled outputs to account.
    logic       stalled = 1'b0;
    logic [2:0] held;
    int         pops = 0;
    int         zeros = 0;
    int         first_cyc = 0;
    int         last_cyc = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (stalled) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'({out_y, out_and}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: y=%0b and=%02b with empty scoreboard", out_y, out_and);
                    end else begin
                        e = sb.pop_front();
                        check("out_y", 32'(out_y), 32'(e.y));
                        check("out_and", 32'(out_and), 32'(e.a));
                        if (pops == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        pops++;
                        if (!out_y) zeros++;
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {out_y, out_and};
            end else begin
                stalled = 1'b0;
            end
        end
    end

`ifdef AOI_PIPE_BIST_EN
    task automatic bist_pulse();
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #1;
    endtask

    task automatic bist_wait(output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (!b_done && n < 300) begin
            if (b_busy) busy_cycles++;
            @(negedge clk);
            #1;
            n++;
        end
        if (!b_done) begin
            errors++;
            $display("FAIL bist_timeout: bist_done never rose");
        end
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_and", 32'(out_and), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: accepted at edge k, visible after edge k+2.
        push(4'b1100);
        @(negedge clk);
        #2;
        check("lat_k1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("lat_k2_valid", 32'(out_valid), 32'd1);
        check("lat_k2_and", 32'(out_and), 32'b10);
        check("lat_k2_y", 32'(out_y), 32'd0);
        push(4'b1010);
        drain();

        // All 16 vectors back to back.
        pops  = 0;
        zeros = 0;
        for (int v = 0; v < 16; v++) push(4'(v));
        drain();
        check("stream_pops", 32'(pops), 32'd16);
        check("stream_zeros", 32'(zeros), 32'd7);
        check("stream_span", 32'(last_cyc - first_cyc), 32'd15);

        // Back-pressure: two fit, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        pops = 0;
        push(4'b0011);
        push(4'b1100);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0000;
        #3;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        push(4'b0000);
        drain();
        check("bp_pops", 32'(pops), 32'd3);

        // Asynchronous reset in the middle of traffic.
        push(4'b0101);
        push(4'b1111);
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(4'b1011);
        drain();

`ifdef AOI_PIPE_BIST_EN
        begin
            int bc;
            bist_pulse();
            bist_wait(bc);
            check("bist1_busy_cycles", 32'(bc), 32'd66);
            check("bist1_done", 32'(b_done), 32'd1);
            check("bist1_pass", 32'(b_pass), 32'd1);
            check("bist1_err", 32'(b_err), 32'd0);

            bist_pulse();
            bist_wait(bc);
            check("bist2_busy_cycles", 32'(bc), 32'd66);
            check("bist2_pass", 32'(b_pass), 32'd1);
            check("bist2_err", 32'(b_err), 32'd0);

            bist_pulse();
            repeat (20) @(negedge clk);
            flip_v = ~u_bist.r_s2_y;
            force u_bist.w_chk_y = flip_v;
            @(negedge clk);
            release u_bist.w_chk_y;
            bist_wait(bc);
            check("bist_flip_err", 32'(b_err), 32'd1);
            check("bist_flip_pass", 32'(b_pass), 32'd0);

            bist_pulse();
            repeat (10) @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("bist_rst_busy", 32'(b_busy), 32'd0);
            check("bist_rst_done", 32'(b_done), 32'd0);
            check("bist_rst_pass", 32'(b_pass), 32'd0);
            check("bist_rst_err", 32'(b_err), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aoi_pipe.md
# aoi_pipe

Parametrised, pipelined AND-OR-INVERT evaluator: `y = ~(|{&term[TERMS-1], …, &term[0]})` over `TERMS` product terms of `TERM_W` bits each. It replaces single-gate AOI instances wherever AOI results feed registered logic, and adds valid/ready flow control. It also has an optional built-in exhaustive self-test that sweeps every input vector through the pipeline.

## Interface
- `TERMS`, default 2: number of product terms, ≥1.
- `TERM_W`, default 2: bits per product term, ≥1.
- `N` (localparam) = `TERMS*TERM_W`: input width. Must be ≤16 when BIST is compiled in.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: stage 1 can accept this cycle.
- `in_data`  in  N: term t occupies bits `[t*TERM_W +: TERM_W]`.
- `out_valid`  out  1: `out_y` and `out_and` are valid.
- `out_ready`  in  1: downstream accepts.
- `out_y`  out  1: AOI result.
- `out_and`  out  TERMS: per-term AND results, aligned with `out_y`.
- BIST-only ports (under macro): `bist_start` in 1, `bist_busy` out 1, `bist_done` out 1, `bist_pass` out 1, `bist_err_cnt` out 8.

## Operation
- Stage 1 registers `s1_and[t] = &in_data[t]` and `s1_v`.
- Stage 2 registers `s2_and = s1_and`, `s2_y = ~|s1_and` and `s2_v`.
- Outputs are driven directly from stage 2. No combinational input-to-output path.
- Handshake:
  - `adv2 = ~s2_v | out_ready`; `adv1 = ~s1_v | adv2`; `in_ready = adv1`.
  - Transfer occurs when valid & ready are both high.
  - A stage holds its data and valid while it is not advancing.
  - `out_valid` never drops without `out_ready`. Data is stable while stalled.
- With no stalls, full throughput: one result per cycle.
- Reset (asynchronous): `s1_v=s2_v=0`, all data registers 0, `out_y=0`, `out_and=0`, `in_ready=1`. BIST returns to IDLE with `bist_busy=bist_done=bist_pass=0` and `bist_err_cnt=0`.

## Timing
- Latency: a vector accepted at edge k appears on the outputs after edge k+2, provided `out_ready=1`.
- Back-pressure: with `out_ready=0`, the pipeline fills two deep, then `in_ready=0` in the same cycle.
- A simultaneous pop and push when full is accepted. Occupancy is unchanged.
- `in_ready` depends combinationally on `out_ready`; this is intended.

## Configuration
- `AOI_PIPE_BIST_EN` defined: BIST ports and controller are present.
  - FSM IDLE → RUN on `bist_start`.
  - RUN: stimulus counter `sc` injects 0…2^N−1, one per cycle. External input is ignored, `in_ready=0`, `out_valid=0`, and internal `out_ready` is forced to 1.
  - A check counter `cc` compares each stage-2 result against the reference function and increments `bist_err_cnt` on mismatch, saturating at 255.
  - RUN → DRAIN after `sc` wraps. DRAIN → DONE when `cc` reaches 2^N. DONE → RUN on `bist_start`.
  - `bist_busy` is high in RUN and DRAIN. `bist_done` is high in DONE. `bist_pass = (bist_err_cnt==0)` and is valid in DONE.
  - `bist_start` is ignored during RUN and DRAIN.
  - On entering RUN, the pipeline is flushed and `bist_err_cnt` is cleared.
- Macro not defined: ports absent. Behaviour is exactly the plain pipeline above.

## Structure
- Package `aoi_pkg` holds:
  - `bist_state_t` enum: IDLE, RUN, DRAIN, DONE.
  - `BIST_ERR_W = 8`.
  - `aoi_ref(vec, TERMS, TERM_W)` reference function.
- Sub-module `aoi_bist_ctrl` holds the FSM, counters and comparator, instantiated only under the macro. The pipeline stays in `aoi_pipe`.

## Test plan
- Reset with `TERMS=2`, `TERM_W=2`, then push 4'b1100 → two cycles later `out_valid=1`, `out_and=2'b10`, `out_y=0`. Push 4'b1010 → `out_and=2'b00`, `out_y=1`.
- Stream all 16 vectors back-to-back with `out_ready=1` → 16 consecutive results in order. `out_y=0` only for vectors with bits[3:2]=11 or bits[1:0]=11 (7 vectors).
- Hold `out_ready=0` and push 3 vectors → `in_ready` falls after 2 are accepted. Outputs are stable. Release `out_ready` → all 3 emerge in order with none lost or duplicated.
- Assert `rst_n=0` mid-stream → `out_valid=0` and `in_ready=1` immediately, before the next clock edge.
- With `AOI_PIPE_BIST_EN`, `TERMS=3`, `TERM_W=2`, pulse `bist_start` → `bist_busy` is high for 64+2 cycles, then `bist_done=1`, `bist_pass=1`, `bist_err_cnt=0`. Pulsing `bist_start` again re-runs with identical results.
- With BIST on, a forced stage-2 bit flip on one vector → `bist_err_cnt=1`, `bist_pass=0`. Reset during RUN → state IDLE and all BIST outputs 0.
